// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, FSM states, default NOP word.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_unit_pkg;

  // addrSel encodings driven by the hazard unit
  localparam logic [1:0] ADDR_PC4    = 2'b00;
  localparam logic [1:0] ADDR_JUMP   = 2'b01;
  localparam logic [1:0] ADDR_BRANCH = 2'b10;
  localparam logic [1:0] ADDR_JR     = 2'b11;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // REQ : request on the bus, waiting for ack
  // HELD: word buffered locally, bus idle
  // DROP: stale pre-reset request still in flight, its data is discarded
  typedef enum logic [1:0] {
    S_REQ  = 2'b00,
    S_HELD = 2'b01,
    S_DROP = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC mux and PC+4 adder for the fetch stage.
// Latency: combinational.
// Backpressure: none; the caller decides when next_pc is loaded.
// Ports: pc in, addr_sel + three targets in; pc_plus4 and next_pc out.
module fetch_pc_sel import fetch_unit_pkg::*; (
  input  logic [31:0] pc,
  input  logic [1:0]  addr_sel,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  // Wraps modulo 2^32; bits [1:0] pass through unchanged.
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc = pc_plus4;
    case (addr_sel)
      ADDR_JUMP:   next_pc = jump_target;
      ADDR_BRANCH: next_pc = branch_target;
      ADDR_JR:     next_pc = jr_target;
      default:     next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, fetches over an imem req/ack handshake, drives IF/ID.
// Latency: word acked while advancing in cycle N is in ID_Instr after edge N; 1 instr/cycle with zero-wait imem.
// Backpressure: FetchStall freezes the core while a wanted word is missing; PC_write=0 parks the word in a hold reg.
// Ports: Clk/Rst; hazard controls PC_write, IF_write, bubble, addrSel + targets;
//        imem_req/imem_addr out, imem_ack/imem_rdata in; FetchStall, IF_PC and IF/ID outputs.
module fetch_unit import fetch_unit_pkg::*; #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PC_write,
  input  logic        IF_write,
  input  logic        bubble,
  input  logic [1:0]  addrSel,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] JrTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        FetchStall,
  output logic [31:0] IF_PC,
  output logic [31:0] ID_Instr,
  output logic [31:0] ID_PCPlus4,
  output logic        ID_Valid
);

  fetch_state_e state_q, state_d, rst_state;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  hold_q, hold_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pcplus4_q, id_pcplus4_d;
  logic         id_valid_q, id_valid_d;

  logic        avail;
  logic        advance;
  logic        if_id_en;
  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  fetch_pc_sel u_pc_sel (
    .pc            (pc_q),
    .addr_sel      (addrSel),
    .jump_target   (JumpTarget),
    .branch_target (BranchTarget),
    .jr_target     (JrTarget),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc)
  );

  assign avail      = ((state_q == S_REQ) && imem_ack) || (state_q == S_HELD);
  assign advance    = PC_write && avail;
  assign FetchStall = PC_write && !avail;
  assign if_id_en   = IF_write && !FetchStall;
  assign fetch_word = (state_q == S_HELD) ? hold_q : imem_rdata;

  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = pc_q;
  assign IF_PC      = pc_q;
  assign ID_Instr   = id_instr_q;
  assign ID_PCPlus4 = id_pcplus4_q;
  assign ID_Valid   = id_valid_q;

  // A request left unanswered at reset will still be acked later; DROP swallows
  // that ack so it is not mistaken for the RESET_PC fetch.
  always_comb begin
    rst_state = S_REQ;
    if ((state_q != S_HELD) && !imem_ack) rst_state = S_DROP;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (imem_ack && !advance) state_d = S_HELD;
      S_HELD:  if (advance) state_d = S_REQ;
      S_DROP:  if (imem_ack) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if ((state_q == S_REQ) && imem_ack && !advance) hold_d = imem_rdata;
  end

  always_comb begin
    pc_d = pc_q;
    if (advance) pc_d = next_pc;
  end

  // A write with no word available (IF_write=1, PC_write=0, avail=0) is a
  // hazard-unit contract violation; it degrades to a squash.
  always_comb begin
    id_instr_d   = id_instr_q;
    id_pcplus4_d = id_pcplus4_q;
    id_valid_d   = id_valid_q;
    if (if_id_en) begin
      if (bubble || !avail) begin
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
      end else begin
        id_instr_d   = fetch_word;
        id_pcplus4_d = pc_plus4;
        id_valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q      <= rst_state;
      pc_q         <= RESET_PC;
      hold_q       <= 32'h0;
      id_instr_q   <= NOP_INSTR;
      id_pcplus4_q <= 32'h0;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      hold_q       <= hold_d;
      id_instr_q   <= id_instr_d;
      id_pcplus4_q <= id_pcplus4_d;
      id_valid_q   <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-programmable imem model.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PC_write, IF_write, bubble;
  logic [1:0]  addrSel;
  logic [31:0] JumpTarget, BranchTarget, JrTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        FetchStall;
  logic [31:0] IF_PC, ID_Instr, ID_PCPlus4;
  logic        ID_Valid;

  int tests_run = 0;
  int tests_failed = 0;

  // imem model: auto mode acks a request after 'lat' wait cycles with word_of(addr);
  // manual mode drives ack/rdata directly (used for the stale-ack reset case).
  logic        mem_auto;
  int          lat;
  int          wait_cnt = 0;
  logic        ack_man;
  logic [31:0] rdata_man;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  assign imem_ack   = mem_auto ? (imem_req && (wait_cnt >= lat)) : ack_man;
  assign imem_rdata = mem_auto ? word_of(imem_addr) : rdata_man;

  always @(posedge Clk) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  always #5 Clk = ~Clk;

  fetch_unit dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PC_write     (PC_write),
    .IF_write     (IF_write),
    .bubble       (bubble),
    .addrSel      (addrSel),
    .JumpTarget   (JumpTarget),
    .BranchTarget (BranchTarget),
    .JrTarget     (JrTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .FetchStall   (FetchStall),
    .IF_PC        (IF_PC),
    .ID_Instr     (ID_Instr),
    .ID_PCPlus4   (ID_PCPlus4),
    .ID_Valid     (ID_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are then driven at the falling edge.
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1; PC_write = 1'b1; IF_write = 1'b1; bubble = 1'b0; addrSel = 2'b00;
    JumpTarget = 32'h0; BranchTarget = 32'h0; JrTarget = 32'h0;
    mem_auto = 1'b1; lat = 0; ack_man = 1'b0; rdata_man = 32'h0;
    tick();
    tick();
    Rst = 1'b0;
    #1;
    // reset state
    chk("rst_pc",      IF_PC,      32'h0);
    chk("rst_instr",   ID_Instr,   32'h0);
    chk("rst_pcp4",    ID_PCPlus4, 32'h0);
    chk("rst_valid",   ID_Valid,   32'h0);
    chk("rst_req",     imem_req,   32'h1);
    chk("rst_addr",    imem_addr,  32'h0);

    // 1: back-to-back zero-wait fetch
    for (int i = 1; i <= 2; i++) begin
      tick(); #1;
      chk("b2b_addr",  imem_addr,  32'(4 * i));
      chk("b2b_instr", ID_Instr,   word_of(32'(4 * (i - 1))));
      chk("b2b_pcp4",  ID_PCPlus4, 32'(4 * i));
      chk("b2b_valid", ID_Valid,   32'h1);
      chk("b2b_stall", FetchStall, 32'h0);
    end

    // 3: load stall during the ack at PC=8
    PC_write = 1'b0; IF_write = 1'b0; bubble = 1'b1;
    #1;
    chk("ld_stall_fs", FetchStall, 32'h0);
    chk("ld_ack",      imem_ack,   32'h1);
    tick();
    PC_write = 1'b1; IF_write = 1'b1; bubble = 1'b0;
    #1;
    chk("held_req",   imem_req,   32'h0);
    chk("held_pc",    IF_PC,      32'h8);
    chk("held_instr", ID_Instr,   word_of(32'h4));
    chk("held_pcp4",  ID_PCPlus4, 32'h8);
    chk("held_fs",    FetchStall, 32'h0);
    tick();
    lat = 3;
    #1;
    chk("hold_instr", ID_Instr,   word_of(32'h8));
    chk("hold_pcp4",  ID_PCPlus4, 32'hC);
    chk("hold_valid", ID_Valid,   32'h1);
    chk("hold_req",   imem_req,   32'h1);

    // 2: three wait cycles at PC=0xC
    for (int i = 0; i < 3; i++) begin
      if (i != 0) begin tick(); #1; end
      chk("wait_fs",    FetchStall, 32'h1);
      chk("wait_addr",  imem_addr,  32'hC);
      chk("wait_pc",    IF_PC,      32'hC);
      chk("wait_instr", ID_Instr,   word_of(32'h8));
    end
    tick(); #1;
    chk("ackc_fs",   FetchStall, 32'h0);
    chk("ackc_addr", imem_addr,  32'hC);
    tick();
    lat = 0;
    // 4: jump from 0x10 to 0x40
    addrSel = 2'b01; JumpTarget = 32'h40;
    #1;
    chk("adv_pc",    IF_PC,      32'h10);
    chk("adv_instr", ID_Instr,   word_of(32'hC));
    chk("adv_pcp4",  ID_PCPlus4, 32'h10);
    tick();
    addrSel = 2'b00; bubble = 1'b1;
    #1;
    chk("jmp_pc",    IF_PC,      32'h40);
    chk("jmp_instr", ID_Instr,   word_of(32'h10));
    chk("jmp_pcp4",  ID_PCPlus4, 32'h14);
    tick();
    bubble = 1'b0;
    // 5: branch then jr
    addrSel = 2'b10; BranchTarget = 32'h100;
    #1;
    chk("bub_instr", ID_Instr,   32'h0);
    chk("bub_valid", ID_Valid,   32'h0);
    chk("bub_pcp4",  ID_PCPlus4, 32'h14);
    chk("bub_pc",    IF_PC,      32'h44);
    tick();
    addrSel = 2'b11; JrTarget = 32'h200;
    #1;
    chk("br_pc",    IF_PC,      32'h100);
    chk("br_instr", ID_Instr,   word_of(32'h44));
    chk("br_pcp4",  ID_PCPlus4, 32'h48);
    tick();
    addrSel = 2'b00;
    #1;
    chk("jr_pc",    IF_PC,      32'h200);
    chk("jr_instr", ID_Instr,   word_of(32'h100));
    chk("jr_pcp4",  ID_PCPlus4, 32'h104);
    tick();
    // 6: reset with a request outstanding, stale ack two cycles later
    mem_auto = 1'b0; ack_man = 1'b0; rdata_man = 32'hDEAD_BEEF; Rst = 1'b1;
    #1;
    chk("pre_pc",   IF_PC,      32'h204);
    chk("pre_pcp4", ID_PCPlus4, 32'h204);
    chk("pre_fs",   FetchStall, 32'h1);
    tick();
    Rst = 1'b0;
    #1;
    chk("drop_req",   imem_req,   32'h0);
    chk("drop_pc",    IF_PC,      32'h0);
    chk("drop_valid", ID_Valid,   32'h0);
    chk("drop_fs",    FetchStall, 32'h1);
    tick();
    ack_man = 1'b1;
    #1;
    chk("stale_req", imem_req, 32'h0);
    tick();
    ack_man = 1'b0; mem_auto = 1'b1;
    #1;
    chk("post_req",   imem_req,  32'h1);
    chk("post_addr",  imem_addr, 32'h0);
    chk("post_instr", ID_Instr,  32'h0);
    chk("post_valid", ID_Valid,  32'h0);
    tick(); #1;
    chk("refetch_instr", ID_Instr,   word_of(32'h0));
    chk("refetch_valid", ID_Valid,   32'h1);
    chk("refetch_pcp4",  ID_PCPlus4, 32'h4);
    chk("refetch_addr",  imem_addr,  32'h4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
